enhanced_cu: RTL and testbench
==============================

# enhanced_cu

Control unit for the enhanced 8-bit processor: a Moore/Mealy FSM that reads the 3-bit opcode and the A-register status flags (`Aeq0`, `Apos`) from `enhanced_dp` and drives that datapath's nine control lines. It sequences every instruction through fetch, decode and execute. It sits beside `enhanced_dp` in the processor top level and forms the controller side of the datapath control/status interface.

## Interface
Parameters:
- none. All encodings come from the shared package.

Ports:
- `clock` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset; forces START.
- `ir` in 3: opcode from datapath IR[7:5]; sampled only in DECODE.
- `Aeq0` in 1: datapath flag, A == 0.
- `Apos` in 1: datapath flag, A > 0 (signed).
- `enter` in 1: operator input-valid strobe, used by INPUT.
- `IRload` out 1: load IR from memory.
- `JMPmux` out 1: PC source; 0 = PC+1, 1 = IR[4:0].
- `PCload` out 1: load PC.
- `Meminst` out 1: memory address source; 0 = PC, 1 = IR[4:0].
- `MemWr` out 1: memory write of A.
- `Asel` out 2: A source; 00 = add/sub result, 01 = `input1`, 10 = memory, 11 = unused.
- `Aload` out 1: load A.
- `sub` out 1: ALU subtract when 1.
- `halt` out 1: high in HALT.
- `state` out 4: current state, for debug.

## Operation
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
- State encoding:
  - START 0000, FETCH 0001, DECODE 0010.
  - Execute states are {1'b1, opcode}: LOAD 1000, STORE 1001, ADD 1010, SUB 1011, INPUT 1100, JZ 1101, JPOS 1110, HALT 1111.
  - Codes 0011–0111 are illegal and go to START.
- Transitions:
  - START→FETCH→DECODE→{1,ir}.
  - Every execute state returns to START, except HALT (self-loop) and INPUT (see Configuration).
- Outputs are all 0 unless listed for a state:
  - FETCH: IRload=1, PCload=1 (JMPmux=0, so PC increments), Meminst=0.
  - DECODE: Meminst=1.
  - LOAD: Meminst=1, Asel=10, Aload=1.
  - STORE: Meminst=1, MemWr=1.
  - ADD: Meminst=1, Asel=00, Aload=1, sub=0.
  - SUB: Meminst=1, Asel=00, Aload=1, sub=1.
  - INPUT: Asel=01, Aload=1 (gated, see Configuration).
  - JZ: JMPmux=1, PCload=Aeq0 (Mealy).
  - JPOS: JMPmux=1, PCload=Apos (Mealy).
  - HALT: halt=1.
- All other outputs are Moore, decoded from `state` only.
- `ir` is ignored outside DECODE.

## Timing
- Reset: `state`=START and all outputs 0 immediately, asynchronously, including Mealy PCload and halt.
- First rising edge after reset release enters FETCH.
- Instruction length: 4 cycles (START, FETCH, DECODE, EXEC). INPUT may be longer.
- IRload and PCload pulse exactly 1 cycle per instruction in FETCH.
- MemWr is high for exactly 1 cycle per STORE.
- JZ/JPOS: PCload follows the flag combinationally within the execute cycle. The flag must be stable at that cycle's rising edge.
- HALT exits only via reset.
- Reset asserted mid-instruction abandons the instruction. No partial writes occur after assertion.

## Configuration
- `ENHANCED_CU_INPUT_WAIT_EN` defined:
  - INPUT holds while `enter`=0, with Aload=0 and Asel=01.
  - On the cycle `enter`=1: Aload=1, next state START.
- Undefined:
  - INPUT lasts 1 cycle with Aload=1; `enter` is ignored.

## Structure
- Package `enhanced_pkg` holds:
  - opcode constants;
  - the 4-bit state encoding;
  - Asel codes;
  - the control-word bit order {IRload,JMPmux,PCload,Meminst,MemWr,Asel[1:0],Aload,sub}.
- `enhanced_dp` imports the same package.
- One sub-module, `enhanced_cu_outdec`: combinational state+flags→9-bit control word. The FSM register and next-state logic stay in `enhanced_cu`.

## Test plan
- LOAD: reset, ir=000 → cycle sequence START, FETCH (IRload=1, PCload=1), DECODE (Meminst=1), LOAD (Asel=10, Aload=1, Meminst=1), then START; state 0000→0001→0010→1000→0000.
- SUB and STORE: ir=011 → exec cycle Asel=00, Aload=1, sub=1. ir=001 → Meminst=1, MemWr=1 for exactly 1 cycle.
- Jumps: ir=101 with Aeq0=1 → JMPmux=1, PCload=1. With Aeq0=0 → PCload=0. ir=110 with Apos toggled mid-cycle → PCload tracks Apos.
- INPUT: ir=100 with macro, enter=0 for 5 cycles → state stays 1100, Aload=0; then enter=1 → Aload=1 for 1 cycle, then START. Without macro → Aload=1 for 1 cycle regardless of enter.
- HALT: ir=111 → halt=1 and all controls 0 for 20 cycles while ir changes. Assert reset mid-cycle → halt=0 and state=0000 before the next edge.
- Reset mid-FETCH: reset asserted while IRload=1 → IRload drops immediately; after release the sequence restarts at START.

Source files
------------

// File: rtl/enhanced_pkg.sv
// ---------------------------------------------------------------------------
// enhanced_pkg
// Shared encodings for the enhanced 8-bit processor. Both enhanced_cu and
// enhanced_dp import this package so that the two sides agree on opcodes,
// state codes, A-register source selects and the control-word layout.
//
// Contents:
//   OP_*        3-bit opcodes carried in IR[7:5]
//   state_t     4-bit controller state; execute states are {1'b1, opcode}
//   ASEL_*      A-register source select codes (2'b11 is reserved)
//   ctrl_t      9-bit control word, MSB first:
//               {IRload, JMPmux, PCload, Meminst, MemWr, Asel[1:0], Aload, sub}
//   CTRL_IDLE   all control lines inactive
// ---------------------------------------------------------------------------
package enhanced_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // Execute states reuse the opcode in the low three bits so DECODE can
    // jump straight to {1'b1, ir}. Codes 0011..0111 have no meaning.
    typedef enum logic [3:0] {
        ST_START  = 4'b0000,
        ST_FETCH  = 4'b0001,
        ST_DECODE = 4'b0010,
        ST_LOAD   = {1'b1, OP_LOAD},
        ST_STORE  = {1'b1, OP_STORE},
        ST_ADD    = {1'b1, OP_ADD},
        ST_SUB    = {1'b1, OP_SUB},
        ST_INPUT  = {1'b1, OP_INPUT},
        ST_JZ     = {1'b1, OP_JZ},
        ST_JPOS   = {1'b1, OP_JPOS},
        ST_HALT   = {1'b1, OP_HALT}
    } state_t;

    localparam logic [1:0] ASEL_ALU   = 2'b00;
    localparam logic [1:0] ASEL_INPUT = 2'b01;
    localparam logic [1:0] ASEL_MEM   = 2'b10;

    typedef struct packed {
        logic       irLoad;
        logic       jmpMux;
        logic       pcLoad;
        logic       memInst;
        logic       memWr;
        logic [1:0] aSel;
        logic       aLoad;
        logic       sub;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Map an opcode onto its execute state.
    function automatic state_t execState(input logic [2:0] op);
        return state_t'({1'b1, op});
    endfunction

endpackage

// File: rtl/enhanced_cu_outdec.sv
// ---------------------------------------------------------------------------
// enhanced_cu_outdec
// Combinational output decoder for the enhanced control unit. Produces the
// 9-bit datapath control word from the current state and, for the Mealy
// cases, from the A-register flags and the operator enter strobe.
//
// Ports:
//   i_state   current controller state
//   i_aeq0    datapath flag A == 0 (drives PCload in JZ)
//   i_apos    datapath flag A > 0 signed (drives PCload in JPOS)
//   i_enter   operator input-valid strobe (used only when INPUT waits)
//   o_ctrl    control word {IRload,JMPmux,PCload,Meminst,MemWr,Asel,Aload,sub}
//
// Build option:
//   ENHANCED_CU_INPUT_WAIT_EN  when defined, Aload in INPUT follows i_enter;
//                              otherwise INPUT loads A unconditionally.
// ---------------------------------------------------------------------------
module enhanced_cu_outdec
    import enhanced_pkg::*;
(
    input  state_t i_state,
    input  logic   i_aeq0,
    input  logic   i_apos,
    input  logic   i_enter,
    output ctrl_t  o_ctrl
);

    // Every line defaults to inactive; each state only raises what it needs.
    // Illegal state codes fall through to the idle word.
    always_comb begin
        o_ctrl = CTRL_IDLE;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.irLoad = 1'b1;
                o_ctrl.pcLoad = 1'b1;
            end
            ST_DECODE: begin
                o_ctrl.memInst = 1'b1;
            end
            ST_LOAD: begin
                o_ctrl.memInst = 1'b1;
                o_ctrl.aSel    = ASEL_MEM;
                o_ctrl.aLoad   = 1'b1;
            end
            ST_STORE: begin
                o_ctrl.memInst = 1'b1;
                o_ctrl.memWr   = 1'b1;
            end
            ST_ADD: begin
                o_ctrl.memInst = 1'b1;
                o_ctrl.aSel    = ASEL_ALU;
                o_ctrl.aLoad   = 1'b1;
            end
            ST_SUB: begin
                o_ctrl.memInst = 1'b1;
                o_ctrl.aSel    = ASEL_ALU;
                o_ctrl.aLoad   = 1'b1;
                o_ctrl.sub     = 1'b1;
            end
            ST_INPUT: begin
                o_ctrl.aSel = ASEL_INPUT;
`ifdef ENHANCED_CU_INPUT_WAIT_EN
                o_ctrl.aLoad = i_enter;
`else
                o_ctrl.aLoad = 1'b1;
`endif
            end
            // Conditional jumps: the branch target is always selected, and
            // the PC is loaded only when the flag says the branch is taken.
            ST_JZ: begin
                o_ctrl.jmpMux = 1'b1;
                o_ctrl.pcLoad = i_aeq0;
            end
            ST_JPOS: begin
                o_ctrl.jmpMux = 1'b1;
                o_ctrl.pcLoad = i_apos;
            end
            default: begin
            end
        endcase
    end

`ifndef ENHANCED_CU_INPUT_WAIT_EN
    // Without the wait option the enter strobe has no effect on the outputs.
    logic w_unusedEnter;
    assign w_unusedEnter = i_enter;
`endif

endmodule

// File: rtl/enhanced_cu.sv
// ---------------------------------------------------------------------------
// enhanced_cu
// Control unit for the enhanced 8-bit processor. Sequences each instruction
// through START, FETCH, DECODE and one execute state chosen by the opcode,
// and drives the control lines of enhanced_dp.
//
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous active-high reset, forces START
//   ir        opcode IR[7:5], sampled only in DECODE
//   Aeq0      datapath flag A == 0
//   Apos      datapath flag A > 0 (signed)
//   enter     operator input-valid strobe
//   IRload, JMPmux, PCload, Meminst, MemWr, Asel[1:0], Aload, sub
//             datapath control lines
//   halt      high while in HALT
//   state     current state, for debug
//
// Build option:
//   ENHANCED_CU_INPUT_WAIT_EN  when defined, INPUT waits for enter before
//                              loading A and returning to START.
// ---------------------------------------------------------------------------
module enhanced_cu
    import enhanced_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] ir,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       enter,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       sub,
    output logic       halt,
    output logic [3:0] state
);

    state_t r_state;
    ctrl_t  w_ctrl;

    // State register and next-state logic. Every execute state returns to
    // START except HALT, which only reset can leave, and INPUT when it is
    // built to wait for the operator. Unused codes recover to START.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_START;
        end else begin
            case (r_state)
                ST_START:  r_state <= ST_FETCH;
                ST_FETCH:  r_state <= ST_DECODE;
                ST_DECODE: r_state <= execState(ir);
                ST_HALT:   r_state <= ST_HALT;
`ifdef ENHANCED_CU_INPUT_WAIT_EN
                ST_INPUT:  r_state <= enter ? ST_START : ST_INPUT;
`endif
                default:   r_state <= ST_START;
            endcase
        end
    end

    enhanced_cu_outdec u_outdec (
        .i_state (r_state),
        .i_aeq0  (Aeq0),
        .i_apos  (Apos),
        .i_enter (enter),
        .o_ctrl  (w_ctrl)
    );

    // Outputs decode straight from the state register, so reset clears
    // them as soon as it asserts.
    assign IRload  = w_ctrl.irLoad;
    assign JMPmux  = w_ctrl.jmpMux;
    assign PCload  = w_ctrl.pcLoad;
    assign Meminst = w_ctrl.memInst;
    assign MemWr   = w_ctrl.memWr;
    assign Asel    = w_ctrl.aSel;
    assign Aload   = w_ctrl.aLoad;
    assign sub     = w_ctrl.sub;
    assign halt    = (r_state == ST_HALT);
    assign state   = r_state;

endmodule

// File: tb/tb_enhanced_cu.sv
// ---------------------------------------------------------------------------
// tb_enhanced_cu
// Self-checking bench for enhanced_cu. A small instruction-level model
// tracks which phase of an instruction the controller should be in and
// which opcode it is executing, and derives the expected control lines
// from the instruction table.
// ---------------------------------------------------------------------------
module tb_enhanced_cu;

`ifdef ENHANCED_CU_INPUT_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] ir;
    logic       Aeq0;
    logic       Apos;
    logic       enter;
    logic       IRload;
    logic       JMPmux;
    logic       PCload;
    logic       Meminst;
    logic       MemWr;
    logic [1:0] Asel;
    logic       Aload;
    logic       sub;
    logic       halt;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 = START, 1 = FETCH, 2 = DECODE, 3 = execute of mOp.
    int         mPhase = 0;
    logic [2:0] mOp    = 3'b000;

    enhanced_cu dut (
        .clock   (clock),
        .reset   (reset),
        .ir      (ir),
        .Aeq0    (Aeq0),
        .Apos    (Apos),
        .enter   (enter),
        .IRload  (IRload),
        .JMPmux  (JMPmux),
        .PCload  (PCload),
        .Meminst (Meminst),
        .MemWr   (MemWr),
        .Asel    (Asel),
        .Aload   (Aload),
        .sub     (sub),
        .halt    (halt),
        .state   (state)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clock = ~clock;

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected {IRload,JMPmux,PCload,Meminst,MemWr,Asel,Aload,sub,halt}.
    function automatic logic [9:0] expWord(input int phase, input logic [2:0] op,
                                           input logic a0, input logic ap, input logic ent);
        logic irl, jmp, pcl, mi, mw, al, sb, hl;
        logic [1:0] as;
        {irl, jmp, pcl, mi, mw, al, sb, hl} = '0;
        as = 2'b00;
        if (phase == 1) begin
            irl = 1'b1;
            pcl = 1'b1;
        end else if (phase == 2) begin
            mi = 1'b1;
        end else if (phase == 3) begin
            case (op)
                3'd0: begin mi = 1'b1; as = 2'b10; al = 1'b1; end
                3'd1: begin mi = 1'b1; mw = 1'b1; end
                3'd2: begin mi = 1'b1; al = 1'b1; end
                3'd3: begin mi = 1'b1; al = 1'b1; sb = 1'b1; end
                3'd4: begin as = 2'b01; al = WAIT_EN ? ent : 1'b1; end
                3'd5: begin jmp = 1'b1; pcl = a0; end
                3'd6: begin jmp = 1'b1; pcl = ap; end
                default: hl = 1'b1;
            endcase
        end
        return {irl, jmp, pcl, mi, mw, as, al, sb, hl};
    endfunction

    // Compare all control lines and the state code against the model.
    task automatic checkOutput(input string tag);
        logic [9:0] obs;
        logic [9:0] expc;
        logic [3:0] expState;
        obs  = {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, sub, halt};
        expc = expWord(mPhase, mOp, Aeq0, Apos, enter);
        case (mPhase)
            0:       expState = 4'b0000;
            1:       expState = 4'b0001;
            2:       expState = 4'b0010;
            default: expState = {1'b1, mOp};
        endcase
        checks++;
        assert (obs === expc) else begin
            errors++;
            $error("[TB] FAIL %s ctrl: got %b required %b", tag, obs, expc);
        end
        checks++;
        assert (state === expState) else begin
            errors++;
            $error("[TB] FAIL %s state: got %b required %b", tag, state, expState);
        end
    endtask

    // Drive one cycle's inputs. The intended opcode is presented only in the
    // DECODE phase; elsewhere ir is random to show it is ignored. Flags are
    // drawn as a consistent pair (zero, positive or negative).
    task automatic applyStimulus(input logic [2:0] op, input logic ent);
        int f;
        ir    = (mPhase == 2) ? op : 3'($urandom);
        f     = $urandom_range(0, 2);
        Aeq0  = (f == 0);
        Apos  = (f == 1);
        enter = ent;
    endtask

    // Advance one clock and step the model with the inputs seen at the edge.
    task automatic advance();
        @(posedge clock);
        case (mPhase)
            0: mPhase = 1;
            1: mPhase = 2;
            2: begin mOp = ir; mPhase = 3; end
            default: begin
                if (mOp == 3'd7) mPhase = 3;
                else if (mOp == 3'd4 && WAIT_EN && !enter) mPhase = 3;
                else mPhase = 0;
            end
        endcase
        @(negedge clock);
    endtask

    task automatic stepCycle(input logic [2:0] op, input logic ent, input string tag);
        applyStimulus(op, ent);
        #1;
        checkOutput(tag);
        advance();
    endtask

    // Run one whole instruction from START back to START, random enter.
    task automatic runInstr(input logic [2:0] op, input string tag);
        int cnt;
        cnt = 0;
        do begin
            stepCycle(op, 1'($urandom), tag);
            cnt++;
        end while (mPhase != 0 && cnt < 64);
        checks++;
        assert (cnt < 64) else begin
            errors++;
            $error("[TB] FAIL %s budget: got %0d cycles required below 64", tag, cnt);
        end
    endtask

    // Jump instruction with two flag settings applied within the execute
    // cycle; the second setting is what the rising edge sees.
    task automatic runJump(input logic [2:0] op, input logic a0, input logic p0,
                           input logic a1, input logic p1, input string tag);
        repeat (3) stepCycle(op, 1'b0, tag);
        ir = 3'($urandom); enter = 1'b0;
        Aeq0 = a0; Apos = p0;
        #1;
        checkOutput({tag, "A"});
        Aeq0 = a1; Apos = p1;
        #1;
        checkOutput({tag, "B"});
        advance();
    endtask

    initial begin
        int hold;
        reset = 1'b1; ir = 3'b000; Aeq0 = 1'b0; Apos = 1'b0; enter = 1'b0;
        mPhase = 0; mOp = 3'b000;
        $display("[TB] enhanced_cu bench start, input wait build = %0d", WAIT_EN);

        // Reset state, held across clock edges.
        #1 checkOutput("reset");
        @(negedge clock);
        applyStimulus(3'd0, 1'b1);
        #1 checkOutput("resetHeld");
        @(negedge clock);
        reset = 1'b0;

        // Directed arithmetic and memory instructions.
        runInstr(3'd0, "load");
        runInstr(3'd3, "sub");
        runInstr(3'd1, "store");
        runInstr(3'd2, "add");

        // Conditional jumps, taken / not taken / flag changing mid-cycle.
        runJump(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, "jzTaken");
        runJump(3'd5, 1'b0, 1'b1, 1'b0, 1'b0, "jzNot");
        runJump(3'd6, 1'b0, 1'b0, 1'b0, 1'b1, "jposUp");
        runJump(3'd6, 1'b0, 1'b1, 1'b0, 1'b0, "jposDown");

        // INPUT: hold enter low for up to five execute cycles, then raise it.
        repeat (3) stepCycle(3'd4, 1'b0, "input");
        hold = 0;
        while (mPhase == 3 && hold < 5) begin
            stepCycle(3'd4, 1'b0, "inputWait");
            hold++;
        end
        while (mPhase != 0) stepCycle(3'd4, 1'b1, "inputEnter");
        stepCycle(3'd0, 1'b0, "inputDone");

        // Random instruction mix (HALT excluded until the end).
        for (int n = 0; n < 40; n++) begin
            runInstr(3'($urandom_range(0, 6)), "rand");
        end

        // Reset asserted in the middle of FETCH.
        while (mPhase != 0) stepCycle(3'd0, 1'b0, "drain");
        stepCycle(3'd2, 1'b0, "preFetch");
        applyStimulus(3'd2, 1'b0);
        #1 checkOutput("fetch");
        #2 reset = 1'b1;
        mPhase = 0;
        #1 checkOutput("rstFetch");
        @(negedge clock);
        #1 checkOutput("rstFetchHeld");
        reset = 1'b0;
        runInstr(3'd2, "afterRst");

        // HALT: stays put for 20 cycles while ir and flags wander.
        repeat (3) stepCycle(3'd7, 1'b0, "haltEnter");
        for (int n = 0; n < 20; n++) begin
            stepCycle(3'd7, 1'($urandom), "halt");
        end
        applyStimulus(3'd7, 1'b0);
        #1 checkOutput("haltPre");
        #2 reset = 1'b1;
        mPhase = 0;
        #1 checkOutput("haltRst");
        @(negedge clock);
        reset = 1'b0;
        runInstr(3'd1, "postHalt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
